score_scan_ctrl: RTL and testbench
==================================

Name: score_scan_ctrl

Overview:
Converts the binary game score to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto the shared 7-segment bus: each scan slot drives one 4-bit digit into bin2seg and asserts the matching active-low digit common. The block sits between the score counter and bin2seg. Leading zeros are blanked so "42" shows as two lit digits.

Parameters:
NUM_DIGITS, 4, number of display digits; the BCD engine is sized for exactly 4 (values 0..9999).
SCORE_W, 14, width of the binary score input.
SCAN_DIV, 10000, clk cycles each digit stays selected; legal range 2..2^20.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
score_in  in  SCORE_W  binary score, sampled only on an accepted load
score_load  in  1  one-cycle load request
busy  out  1  high while a conversion is in progress
bin_data  out  4  BCD digit to bin2seg, always 0..9
digit_sel  out  NUM_DIGITS  active-low digit commons, one-hot-low or all-high (blank)

Behaviour:
- Reset (async assert, sync release): busy=0, digit registers=0, scan idx=0, divider=0, bin_data=4'd0, digit_sel=4'b1110 (ones digit lit, shows "0").
- Conversion FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: when score_load=1, latch score_in into the shift register. Values above 9999 saturate to 9999. Clear the BCD work register, set bit counter to SCORE_W-1, go to SHIFT, and set busy=1 from the next cycle.
  - SHIFT: each cycle, first add 3 to every BCD nibble that is >=5, then shift {bcd, bin} left by 1. Decrement the counter. After exactly SCORE_W shift cycles, go to COMMIT.
  - COMMIT: copy all four BCD nibbles to the display digit registers in one cycle (atomic update, never a partially updated value), set busy=0, go to IDLE.
  - Latency: load accepted at cycle t; display registers hold the new value at t+SCORE_W+2; busy is high for SCORE_W+1 cycles.
  - score_load while busy is ignored, with no queueing. The caller reloads after busy falls.
  - score_load held high in IDLE starts a new conversion each time the FSM returns to IDLE.
- Scanner (runs independently of the FSM, every cycle):
  - divider counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, divider wraps to 0 and idx advances, wrapping from NUM_DIGITS-1 to 0.
  - bin_data and digit_sel are registered outputs, computed from the current idx and display digits, so they lag idx by one cycle.
  - digit_sel: bit idx is 0 and all other bits are 1, except blanking: if idx>0 and every display digit at positions >= idx is 0, digit_sel is all-ones. bin_data still carries the digit value when blanked.
  - Digit 0 is the ones digit and is never blanked.
  - A COMMIT landing mid-slot takes effect on the next registered output cycle. The scan is not restarted.
- Reset mid-conversion: the FSM returns to IDLE and display digits go to 0. A partial result is never committed.

Decomposition:
- Shared package: BCD_DIGITS=4, BCD_MAX=9999, state encoding (IDLE/SHIFT/COMMIT), and the DIGIT_OFF=1'b1 polarity constant.
- One natural sub-module, bin2bcd_seq: the FSM plus double-dabble datapath, with ports clk, rst_n, start, bin, busy, bcd[15:0], valid.
- The scanner stays in the top module. bin2seg is instantiated by the parent, not inside this block.

Test Plan:
- Reset with SCAN_DIV=4, no load: digit_sel cycles 1110, then 1111 for three slots (all leading zeros blanked), 4 cycles per slot; bin_data=0 throughout.
- Load 1234: busy high for 15 cycles; after commit, the slots show digit0=4/1110, digit1=3/1101, digit2=2/1011, digit3=1/0111.
- Load 42: slots 0 and 1 show 2 and 4; slots 2 and 3 have digit_sel=1111. Load 0: only the ones slot is lit, showing 0.
- Load 16383 (all ones): saturates and displays 9999 on all four digits. A second load during busy (value 5) is ignored and the display stays 9999.
- Load 1205: the middle zero (digit2) is not blanked. Load 1000 then 7 back-to-back after busy falls: the display changes atomically with no mixed value such as 1007.
- Assert rst_n=0 mid-SHIFT after loading 5678: outputs immediately return to their reset values, and no 5678 digits appear after release.

Source files
------------

// File: rtl/score_scan_ctrl_pkg.sv
// Shared definitions for the score display path.
// Contents: BCD sizing constants, conversion FSM state encoding, the digit
// common polarity, and a helper that applies the double-dabble add-3 adjust.
package score_scan_ctrl_pkg;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned BCD_MAX    = 9999;

  // Digit commons are active-low: driving DIGIT_OFF leaves a digit dark.
  localparam logic DIGIT_OFF = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StCommit = 2'd2
  } conv_state_e;

  // Add 3 to every nibble that is >= 5 so the following left shift carries
  // correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/score_scan_ctrl_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : start request, honoured only while idle
//   i_bin      : binary input, saturated to BCD_MAX when latched
//   o_busy     : high from the cycle after start until the result is committed
//   o_bcd      : four packed BCD digits, digit 0 in bits [3:0]
//   o_valid    : one-cycle pulse when o_bcd has just been updated
module bin2bcd_seq
  import score_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCORE_W = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [SCORE_W-1:0] i_bin,
  output logic               o_busy,
  output logic [BCD_W-1:0]   o_bcd,
  output logic               o_valid
);

  localparam int unsigned CntW = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

  conv_state_e        r_state;
  logic [SCORE_W-1:0] r_bin;
  logic [BCD_W-1:0]   r_work;
  logic [CntW-1:0]    r_cnt;
  logic               r_busy;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_valid;

  logic [SCORE_W-1:0] w_bin_sat;
  logic [BCD_W-1:0]   w_adj;

  always_comb begin
    w_bin_sat = i_bin;
    if (32'(i_bin) > BCD_MAX) begin
      w_bin_sat = SCORE_W'(BCD_MAX);
    end
  end

  assign w_adj = bcd_adjust(r_work);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_bin   <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_bcd   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_bin   <= w_bin_sat;
            r_work  <= '0;
            r_cnt   <= CntW'(SCORE_W - 1);
            r_busy  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          r_work <= {w_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
          r_bin  <= r_bin << 1;
          r_cnt  <= r_cnt - CntW'(1);
          if (r_cnt == '0) begin
            r_state <= StCommit;
          end
        end
        StCommit: begin
          // Whole result published at once; the reader never sees a partial value.
          r_bcd   <= r_work;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_bcd   = r_bcd;
  assign o_valid = r_valid;

endmodule

// File: rtl/score_scan_ctrl.sv
// Score display controller: converts the binary score to BCD and scans the
// digits onto a shared 7-segment bus with leading-zero blanking.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_score_in     : binary score, sampled when a load is accepted
//   i_score_load   : one-cycle load request, ignored while busy
//   o_busy         : conversion in progress
//   o_bin_data     : BCD digit for the currently selected slot (to bin2seg)
//   o_digit_sel    : active-low digit commons, one-hot-low or all-high
// The BCD engine covers exactly BCD_DIGITS digits; NUM_DIGITS must match it.
module score_scan_ctrl
  import score_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned SCAN_DIV   = 10000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SCORE_W-1:0]    i_score_in,
  input  logic                  i_score_load,
  output logic                  o_busy,
  output logic [3:0]            o_bin_data,
  output logic [NUM_DIGITS-1:0] o_digit_sel
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  w_busy;
  logic [BCD_W-1:0]      w_bcd;
  logic                  w_valid;
  logic [3:0]            w_digit;
  logic                  w_upper_nz;
  logic [NUM_DIGITS-1:0] w_sel;

  logic [BCD_W-1:0]      r_disp;
  logic [DivW-1:0]       r_div;
  logic [IdxW-1:0]       r_idx;

  bin2bcd_seq #(
    .SCORE_W (SCORE_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_score_load),
    .i_bin   (i_score_in),
    .o_busy  (w_busy),
    .o_bcd   (w_bcd),
    .o_valid (w_valid)
  );

  assign o_busy = w_busy;

  // Select the current digit and decide whether it is a leading zero.
  always_comb begin
    w_digit    = r_disp[4*int'(r_idx) +: 4];
    w_upper_nz = 1'b0;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (i >= int'(r_idx) && r_disp[i*4 +: 4] != 4'd0) begin
        w_upper_nz = 1'b1;
      end
    end
    w_sel = {NUM_DIGITS{DIGIT_OFF}};
    // The ones digit is always lit so a zero score still shows "0".
    if (r_idx == '0 || w_upper_nz) begin
      w_sel[r_idx] = ~DIGIT_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp      <= '0;
      r_div       <= '0;
      r_idx       <= '0;
      o_bin_data  <= 4'd0;
      o_digit_sel <= {{(NUM_DIGITS-1){DIGIT_OFF}}, ~DIGIT_OFF};
    end else begin
      if (w_valid) begin
        r_disp <= w_bcd;
      end
      if (r_div == DivW'(SCAN_DIV - 1)) begin
        r_div <= '0;
        r_idx <= (r_idx == IdxW'(NUM_DIGITS - 1)) ? '0 : r_idx + IdxW'(1);
      end else begin
        r_div <= r_div + DivW'(1);
      end
      o_bin_data  <= w_digit;
      o_digit_sel <= w_sel;
    end
  end

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Self-checking bench for score_scan_ctrl with a cycle-level reference model
// built from decimal arithmetic on the displayed integer value.
module tb_score_scan_ctrl;

  localparam int NUM_DIGITS = 4;
  localparam int SCORE_W    = 14;
  localparam int SCAN_DIV   = 4;

  logic                  clk;
  logic                  rst_n;
  logic [SCORE_W-1:0]    i_score_in;
  logic                  i_score_load;
  logic                  o_busy;
  logic [3:0]            o_bin_data;
  logic [NUM_DIGITS-1:0] o_digit_sel;

  score_scan_ctrl #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCORE_W    (SCORE_W),
    .SCAN_DIV   (SCAN_DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_score_in   (i_score_in),
    .i_score_load (i_score_load),
    .o_busy       (o_busy),
    .o_bin_data   (o_bin_data),
    .o_digit_sel  (o_digit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp,
               $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  // Reference model: display value kept as a plain integer.
  int       m_rem;       // cycles of busy left
  int       m_pend_cnt;  // cycles until the pending value reaches the display
  int       m_pend_val;
  int       m_disp;
  int       m_div;
  int       m_idx;
  int       e_bin;
  bit [3:0] e_sel;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_pend_cnt = 0; m_pend_val = 0; m_disp = 0;
      m_div = 0; m_idx = 0; e_bin = 0; e_sel = 4'b1110;
    end else begin
      e_bin = (m_disp / pow10(m_idx)) % 10;
      e_sel = 4'b1111;
      if (m_idx == 0 || (m_disp / pow10(m_idx)) != 0) e_sel[m_idx] = 1'b0;
      if (m_div == SCAN_DIV - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % NUM_DIGITS;
      end else begin
        m_div++;
      end
      if (m_pend_cnt > 0) begin
        m_pend_cnt--;
        if (m_pend_cnt == 0) m_disp = m_pend_val;
      end
      if (m_rem > 0) begin
        m_rem--;
      end else if (i_score_load) begin
        m_rem      = SCORE_W + 1;
        m_pend_cnt = SCORE_W + 2;
        m_pend_val = (int'(i_score_in) > 9999) ? 9999 : int'(i_score_in);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check_eq("busy", int'(o_busy), (m_rem > 0) ? 1 : 0);
      check_eq("bin_data", int'(o_bin_data), e_bin);
      check_eq("digit_sel", int'(o_digit_sel), int'(e_sel));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the model to be idle, then pulse a load.
  task automatic do_load(input int v);
    int guard = 0;
    while (m_rem != 0 && guard < 100) begin
      tick(1);
      guard++;
    end
    if (guard >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL load_wait: busy did not fall within %0d cycles, required 0", guard);
    end
    i_score_in   = SCORE_W'(v);
    i_score_load = 1'b1;
    tick(1);
    i_score_load = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    i_score_in   = '0;
    i_score_load = 1'b0;
    #12;
    check_eq("reset_busy", int'(o_busy), 0);
    check_eq("reset_bin", int'(o_bin_data), 0);
    check_eq("reset_sel", int'(o_digit_sel), 4'b1110);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    tick(40);                       // idle scan after reset, leading zeros blanked
    do_load(1234);  tick(40);
    do_load(42);    tick(40);
    do_load(0);     tick(40);
    do_load(16383); tick(3);
    i_score_in = SCORE_W'(5); i_score_load = 1'b1; tick(1); i_score_load = 1'b0;
    tick(40);
    do_load(1205);  tick(40);
    do_load(1000);  do_load(7);   tick(40);

    // Load held high: a new conversion each time the FSM is idle again.
    i_score_load = 1'b1;
    for (int i = 0; i < 60; i++) begin
      i_score_in = SCORE_W'($urandom_range(0, 16383));
      tick(1);
    end
    i_score_load = 1'b0;
    tick(20);

    for (int i = 0; i < 15; i++) begin
      do_load(int'($urandom_range(0, 16383)));
      tick(int'($urandom_range(0, 30)));
    end
    do_load(int'($urandom_range(10000, 16383))); tick(40);

    // Reset in the middle of a conversion.
    do_load(5678);
    tick(5);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", int'(o_busy), 0);
    check_eq("midrst_bin", int'(o_bin_data), 0);
    check_eq("midrst_sel", int'(o_digit_sel), 4'b1110);
    tick(3);
    rst_n = 1'b1;
    tick(60);
    check_eq("midrst_disp_model", m_disp, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
